// File: rtl/uart_report_scheduler_pkg.sv
// Shared constants for the UART report scheduler: ASCII codes, FSM encoding,
// requester IDs and per-message lengths.
package uart_report_scheduler_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_U     = 8'h55;
    localparam logic [7:0] ASCII_H     = 8'h48;
    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam logic [1:0] SRC_TIME = 2'd0;
    localparam logic [1:0] SRC_DIST = 2'd1;
    localparam logic [1:0] SRC_DHT  = 2'd2;

    localparam int NUM_SRC    = 3;
    localparam int NUM_DIGITS = 6;

    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

    // Total bytes including the line terminator.
    function automatic logic [3:0] msg_len(input logic [1:0] src, input bit en_crlf);
        logic [3:0] body_and_lf;
        case (src)
            SRC_TIME: body_and_lf = 4'd9;
            SRC_DIST: body_and_lf = 4'd6;
            default:  body_and_lf = 4'd10;
        endcase
        return en_crlf ? body_and_lf + 4'd1 : body_and_lf;
    endfunction

    function automatic logic [1:0] next_src(input logic [1:0] src);
        return (src == SRC_DHT) ? SRC_TIME : src + 2'd1;
    endfunction

    // First pending requester at or after ptr, wrapping time > dist > dht.
    function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] ptr);
        logic [1:0] cand;
        logic [1:0] pick;
        logic       found;
        cand  = ptr;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && pend[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = next_src(cand);
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_report_scheduler_bcd_to_ascii.sv
// Combinational BCD digit to ASCII; non-decimal codes render as '-'.
module bcd_to_ascii
    import uart_report_scheduler_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ascii
);

    assign ascii = (digit <= 4'd9) ? (ASCII_ZERO + {4'h0, digit}) : ASCII_DASH;

endmodule

// File: rtl/uart_report_scheduler.sv
// Arbitrates time/distance/DHT report requests and pushes each ASCII message
// byte-by-byte into the UART TX FIFO, honouring the FIFO full flag.
module uart_report_scheduler
    import uart_report_scheduler_pkg::*;
#(
    parameter bit EN_CRLF = 1'b1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iFull,
    input  logic       iTime_En,
    input  logic [3:0] iHour_10,
    input  logic [3:0] iHour_1,
    input  logic [3:0] iMin_10,
    input  logic [3:0] iMin_1,
    input  logic [3:0] iSec_10,
    input  logic [3:0] iSec_1,
    input  logic       iDist_En,
    input  logic [3:0] iDist_100,
    input  logic [3:0] iDist_10,
    input  logic [3:0] iDist_1,
    input  logic       iDht_En,
    input  logic [3:0] iHum_10,
    input  logic [3:0] iHum_1,
    input  logic [3:0] iTemp_10,
    input  logic [3:0] iTemp_1,
    output logic       oPush,
    output logic [7:0] oAscii,
    output logic       oBusy,
    output logic [2:0] oDrop
);

    logic [1:0] state_q, state_d;
    logic [1:0] rr_q, rr_d;
    logic [1:0] src_q, src_d;
    logic [2:0] pend_q, pend_d;
    logic [2:0] drop_q, drop_d;
    digits_t    snap_q, snap_d;
    logic [3:0] idx_q, idx_d;
    logic       push_q, push_d;
    logic [7:0] ascii_q, ascii_d;

    logic [2:0] strobe;
    logic [2:0] clear;
    logic [1:0] grant;
    logic [1:0] cur_src;
    digits_t    live_digits;
    digits_t    cur_digits;
    logic [3:0] cur_len;
    logic [2:0] dsel;
    logic       is_digit;
    logic [7:0] const_char;
    logic [3:0] digit;
    logic [7:0] digit_ascii;
    logic [7:0] byte_ascii;

    assign strobe = {iDht_En, iDist_En, iTime_En};
    assign grant  = rr_pick(pend_q, rr_q);

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        live_digits = '0;
        case (grant)
            SRC_TIME: begin
                live_digits[0] = iHour_10;
                live_digits[1] = iHour_1;
                live_digits[2] = iMin_10;
                live_digits[3] = iMin_1;
                live_digits[4] = iSec_10;
                live_digits[5] = iSec_1;
            end
            SRC_DIST: begin
                live_digits[0] = iDist_100;
                live_digits[1] = iDist_10;
                live_digits[2] = iDist_1;
            end
            default: begin
                live_digits[0] = iHum_10;
                live_digits[1] = iHum_1;
                live_digits[2] = iTemp_10;
                live_digits[3] = iTemp_1;
            end
        endcase
    end

    // Byte 0 is issued in LOAD, so it reads the live digits the snapshot is taking.
    assign cur_src    = (state_q == ST_LOAD) ? grant : src_q;
    assign cur_digits = (state_q == ST_LOAD) ? live_digits : snap_q;
    assign cur_len    = msg_len(cur_src, EN_CRLF);

    always_comb begin
        is_digit   = 1'b0;
        dsel       = 3'd0;
        const_char = ASCII_LF;
        if (idx_q == cur_len - 4'd1) begin
            const_char = ASCII_LF;
        end else if (EN_CRLF && (idx_q == cur_len - 4'd2)) begin
            const_char = ASCII_CR;
        end else begin
            case (cur_src)
                SRC_TIME: begin
                    case (idx_q)
                        4'd0:    begin is_digit = 1'b1; dsel = 3'd0; end
                        4'd1:    begin is_digit = 1'b1; dsel = 3'd1; end
                        4'd3:    begin is_digit = 1'b1; dsel = 3'd2; end
                        4'd4:    begin is_digit = 1'b1; dsel = 3'd3; end
                        4'd6:    begin is_digit = 1'b1; dsel = 3'd4; end
                        4'd7:    begin is_digit = 1'b1; dsel = 3'd5; end
                        default: const_char = ASCII_COLON;
                    endcase
                end
                SRC_DIST: begin
                    case (idx_q)
                        4'd0:    const_char = ASCII_U;
                        4'd1:    const_char = ASCII_COLON;
                        default: begin is_digit = 1'b1; dsel = 3'(idx_q - 4'd2); end
                    endcase
                end
                default: begin
                    case (idx_q)
                        4'd0:    const_char = ASCII_H;
                        4'd1:    const_char = ASCII_COLON;
                        4'd2:    begin is_digit = 1'b1; dsel = 3'd0; end
                        4'd3:    begin is_digit = 1'b1; dsel = 3'd1; end
                        4'd4:    const_char = ASCII_SPACE;
                        4'd5:    const_char = ASCII_T;
                        4'd6:    const_char = ASCII_COLON;
                        4'd7:    begin is_digit = 1'b1; dsel = 3'd2; end
                        default: begin is_digit = 1'b1; dsel = 3'd3; end
                    endcase
                end
            endcase
        end
    end

    assign digit = cur_digits[dsel];

    bcd_to_ascii u_bcd_to_ascii (
        .digit (digit),
        .ascii (digit_ascii)
    );

    assign byte_ascii = is_digit ? digit_ascii : const_char;

    // A new strobe wins over the grant clearing the same requester.
    always_comb begin
        clear = '0;
        if (state_q == ST_LOAD) begin
            clear[grant] = 1'b1;
        end
        pend_d = (pend_q & ~clear) | strobe;
        drop_d = strobe & pend_q & ~clear;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        src_d   = src_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        push_d  = 1'b0;
        ascii_d = ascii_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = 4'd0;
                if (|pend_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                src_d   = grant;
                snap_d  = live_digits;
                rr_d    = next_src(grant);
                state_d = ST_SEND;
                if (!iFull) begin
                    push_d  = 1'b1;
                    ascii_d = byte_ascii;
                    idx_d   = 4'd1;
                end else begin
                    idx_d = 4'd0;
                end
            end
            ST_SEND: begin
                // Leave once every byte has been issued; the last push is on oPush now.
                if (idx_q == cur_len) begin
                    state_d = ST_IDLE;
                    idx_d   = 4'd0;
                end else if (!iFull) begin
                    push_d  = 1'b1;
                    ascii_d = byte_ascii;
                    idx_d   = idx_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            rr_q    <= SRC_TIME;
            src_q   <= SRC_TIME;
            pend_q  <= '0;
            drop_q  <= '0;
            snap_q  <= '0;
            idx_q   <= 4'd0;
            push_q  <= 1'b0;
            ascii_q <= 8'h00;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            push_q  <= push_d;
            ascii_q <= ascii_d;
        end
    end

    assign oPush  = push_q;
    assign oAscii = ascii_q;
    assign oBusy  = (state_q != ST_IDLE);
    assign oDrop  = drop_q;

endmodule

// File: tb/tb_uart_report_scheduler.sv
// Self-checking bench: directed scenarios plus randomized request bursts checked
// against a string-based message model; runs CRLF and LF-only instances side by side.
module tb_uart_report_scheduler;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       full;
    logic       time_en, dist_en, dht_en;
    logic [3:0] h10, h1, m10, m1, s10, s1;
    logic [3:0] d100, d10, d1;
    logic [3:0] hu10, hu1, t10, t1;

    logic       push_a, push_b;
    logic [7:0] ascii_a, ascii_b;
    logic       busy_a, busy_b;
    logic [2:0] drop_a, drop_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bq_t  rx_a, rx_b, exp_a, exp_b;
    int   pcyc[$];
    int   drops_a[3];
    int   drops_b[3];
    logic full_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_report_scheduler #(.EN_CRLF(1'b1)) dut (
        .iClk(clk), .iRst(rst), .iFull(full),
        .iTime_En(time_en),
        .iHour_10(h10), .iHour_1(h1), .iMin_10(m10), .iMin_1(m1), .iSec_10(s10), .iSec_1(s1),
        .iDist_En(dist_en), .iDist_100(d100), .iDist_10(d10), .iDist_1(d1),
        .iDht_En(dht_en), .iHum_10(hu10), .iHum_1(hu1), .iTemp_10(t10), .iTemp_1(t1),
        .oPush(push_a), .oAscii(ascii_a), .oBusy(busy_a), .oDrop(drop_a)
    );

    uart_report_scheduler #(.EN_CRLF(1'b0)) dut_lf (
        .iClk(clk), .iRst(rst), .iFull(full),
        .iTime_En(time_en),
        .iHour_10(h10), .iHour_1(h1), .iMin_10(m10), .iMin_1(m1), .iSec_10(s10), .iSec_1(s1),
        .iDist_En(dist_en), .iDist_100(d100), .iDist_10(d10), .iDist_1(d1),
        .iDht_En(dht_en), .iHum_10(hu10), .iHum_1(hu1), .iTemp_10(t10), .iTemp_1(t1),
        .oPush(push_b), .oAscii(ascii_b), .oBusy(busy_b), .oDrop(drop_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output monitor: records pushes, drop pulses, and checks no push follows a full cycle.
    always @(negedge clk) begin
        if (full_prev) begin
            check("push while full", {31'd0, push_a}, 32'd0);
        end
        if (push_a === 1'b1) begin
            rx_a.push_back(ascii_a);
            pcyc.push_back(cyc);
        end
        if (push_b === 1'b1) rx_b.push_back(ascii_b);
        for (int i = 0; i < 3; i++) begin
            drops_a[i] += int'(drop_a[i]);
            drops_b[i] += int'(drop_b[i]);
        end
        full_prev = full;
    end

    function automatic logic [7:0] asc(input logic [3:0] d);
        return (d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h2D;
    endfunction

    task automatic add_msg(input int src);
        string s;
        case (src)
            0:       s = $sformatf("%c%c:%c%c:%c%c", asc(h10), asc(h1), asc(m10), asc(m1), asc(s10), asc(s1));
            1:       s = $sformatf("U:%c%c%c", asc(d100), asc(d10), asc(d1));
            default: s = $sformatf("H:%c%c T:%c%c", asc(hu10), asc(hu1), asc(t10), asc(t1));
        endcase
        for (int i = 0; i < s.len(); i++) begin
            exp_a.push_back(s[i]);
            exp_b.push_back(s[i]);
        end
        exp_a.push_back(8'h0D);
        exp_a.push_back(8'h0A);
        exp_b.push_back(8'h0A);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] mask);
        time_en = mask[0];
        dist_en = mask[1];
        dht_en  = mask[2];
        tick();
        time_en = 1'b0;
        dist_en = 1'b0;
        dht_en  = 1'b0;
    endtask

    task automatic set_time(input logic [3:0] a, b, c, d, e, f);
        h10 = a; h1 = b; m10 = c; m1 = d; s10 = e; s1 = f;
    endtask

    task automatic clear_all();
        rx_a.delete(); rx_b.delete(); exp_a.delete(); exp_b.delete(); pcyc.delete();
        for (int i = 0; i < 3; i++) begin
            drops_a[i] = 0;
            drops_b[i] = 0;
        end
    endtask

    task automatic wait_idle(input string tag, input bit rand_full);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 3000) begin
            if (rand_full) full = ($urandom_range(0, 3) == 0);
            tick();
            n++;
            if (busy_a === 1'b0 && busy_b === 1'b0 && push_a === 1'b0 && push_b === 1'b0) quiet++;
            else quiet = 0;
        end
        full = 1'b0;
        tick(2);
        check({tag, " idle reached"}, {31'd0, n < 3000}, 32'd1);
    endtask

    task automatic compare_rx(input string tag);
        check({tag, " length"}, rx_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size(); i++)
            if (i < rx_a.size()) check($sformatf("%s byte%0d", tag, i), {24'd0, rx_a[i]}, {24'd0, exp_a[i]});
        check({tag, " lf length"}, rx_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            if (i < rx_b.size()) check($sformatf("%s lf byte%0d", tag, i), {24'd0, rx_b[i]}, {24'd0, exp_b[i]});
        clear_all();
    endtask

    initial begin
        int sc, n, sz0, rr_m, last;
        logic [2:0] mask;

        rst = 1'b1; full = 1'b0;
        time_en = 1'b0; dist_en = 1'b0; dht_en = 1'b0;
        set_time(0, 0, 0, 0, 0, 0);
        d100 = 0; d10 = 0; d1 = 0; hu10 = 0; hu1 = 0; t10 = 0; t1 = 0;
        clear_all();
        tick(3);
        check("reset push", {31'd0, push_a}, 32'd0);
        check("reset ascii", {24'd0, ascii_a}, 32'h00);
        check("reset busy", {31'd0, busy_a}, 32'd0);
        check("reset drop", {29'd0, drop_a}, 32'd0);
        check("reset lf push", {31'd0, push_b}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Single time report, latency and back-to-back bytes.
        set_time(1, 2, 3, 4, 5, 6);
        clear_all();
        add_msg(0);
        sc = cyc;
        pulse(3'b001);
        wait_idle("time", 1'b0);
        check("time first push latency", (pcyc.size() > 0) ? pcyc[0] - sc : -1, 32'd3);
        check("time back-to-back", (pcyc.size() == 10) ? pcyc[9] - pcyc[0] : -1, 32'd9);
        compare_rx("time");

        // All three at once from a fresh reset: time, dist, dht.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        d100 = 0; d10 = 8; d1 = 7; hu10 = 4; hu1 = 5; t10 = 2; t1 = 7;
        clear_all();
        add_msg(0); add_msg(1); add_msg(2);
        pulse(3'b111);
        wait_idle("all3", 1'b0);
        check("all3 idle gaps", {31'd0, pcyc.size() >= 28 && (pcyc[10] - pcyc[9]) >= 3
              && (pcyc[17] - pcyc[16]) >= 3}, 32'd1);
        check("all3 no drops", drops_a[0] + drops_a[1] + drops_a[2] + drops_b[0] + drops_b[1] + drops_b[2], 32'd0);
        compare_rx("all3");

        // FIFO full for 5 cycles mid distance message.
        add_msg(1);
        pulse(3'b010);
        n = 0;
        while (rx_a.size() < 3 && n < 100) begin tick(); n++; end
        check("full reach byte3", {31'd0, n < 100}, 32'd1);
        sz0 = rx_a.size();
        full = 1'b1;
        tick(5);
        check("full stall", {31'd0, (rx_a.size() - sz0) <= 1}, 32'd1);
        full = 1'b0;
        wait_idle("full", 1'b0);
        compare_rx("full");

        // Distance strobed twice while already pending behind a time message.
        add_msg(0); add_msg(1);
        pulse(3'b001);
        tick();
        pulse(3'b010);
        tick(2);
        pulse(3'b010);
        wait_idle("drop", 1'b0);
        check("drop dist count", drops_a[1], 32'd1);
        check("drop others", drops_a[0] + drops_a[2], 32'd0);
        check("drop lf dist count", drops_b[1], 32'd1);
        compare_rx("drop");

        // Snapshot: digits change right after LOAD; 4'hA renders '-'.
        set_time(4'hA, 1, 2, 3, 4, 5);
        add_msg(0);
        pulse(3'b001);
        tick(2);
        set_time(9, 8, 7, 6, 0, 0);
        wait_idle("snap", 1'b0);
        compare_rx("snap");

        // Reset after the 4th byte of a time report.
        set_time(1, 2, 3, 4, 5, 6);
        add_msg(0);
        pulse(3'b001);
        n = 0;
        while (rx_a.size() < 4 && n < 100) begin @(negedge clk); #1; n++; end
        check("rst reach byte4", {31'd0, n < 100}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst push now", {31'd0, push_a}, 32'd0);
        check("rst lf push now", {31'd0, push_b}, 32'd0);
        check("rst busy now", {31'd0, busy_a}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(20);
        check("rst no resume", rx_a.size(), 32'd4);
        check("rst lf no resume", rx_b.size(), 32'd4);
        check("rst idle", {31'd0, busy_a}, 32'd0);
        for (int i = 0; i < 4; i++)
            if (i < rx_a.size()) check($sformatf("rst byte%0d", i), {24'd0, rx_a[i]}, {24'd0, exp_a[i]});
        clear_all();

        // Randomized bursts with random back-pressure; order follows the rotating pointer.
        rr_m = 0;
        for (int it = 0; it < 25; it++) begin
            set_time(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            d100 = 4'($urandom_range(0, 15)); d10 = 4'($urandom_range(0, 15)); d1 = 4'($urandom_range(0, 15));
            hu10 = 4'($urandom_range(0, 15)); hu1 = 4'($urandom_range(0, 15));
            t10  = 4'($urandom_range(0, 15)); t1  = 4'($urandom_range(0, 15));
            mask = 3'($urandom_range(1, 7));
            last = rr_m;
            for (int k = 0; k < 3; k++) begin
                if (mask[(rr_m + k) % 3]) begin
                    add_msg((rr_m + k) % 3);
                    last = (rr_m + k) % 3;
                end
            end
            rr_m = (last + 1) % 3;
            pulse(mask);
            wait_idle($sformatf("rand%0d", it), 1'b1);
            check($sformatf("rand%0d drops", it), drops_a[0] + drops_a[1] + drops_a[2], 32'd0);
            compare_rx($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
